// File: rtl/axis_labcontrol_multichannel.sv
// LabControl-bus receiver: decodes host writes to NUM_CHANNELS consecutive addresses,
// buffers them in a FIFO and streams them out on AXI4-Stream with TDEST/TUSER.
module axis_labcontrol_multichannel #(
   parameter int unsigned AXIS_DATA_WIDTH = 16,
   parameter int unsigned LC_DATA_WIDTH   = 16,
   parameter int unsigned LC_ADDR_WIDTH   = 8,
   parameter int unsigned LC_BASE_ADDRESS = 'hF0,
   parameter int unsigned NUM_CHANNELS    = 4,
   parameter int unsigned CHAN_WIDTH      = 4,
   parameter int unsigned FIFO_DEPTH      = 8,
   parameter int unsigned SIGN_EXTEND     = 1,
   parameter int unsigned SYNC_STAGES     = 2
) (
   input  logic                               m_axis_aclk,
   input  logic                               m_axis_areset,
   output logic [AXIS_DATA_WIDTH-1:0]         m_axis_tdata,
   output logic                               m_axis_tvalid,
   input  logic                               m_axis_tready,
   output logic [CHAN_WIDTH-1:0]              m_axis_tdest,
   output logic [2:0]                         m_axis_tuser,
   input  logic [7:0]                         DIOA,
   input  logic [7:0]                         DIOB,
   input  logic [7:0]                         DIOC,
   input  logic [7:0]                         DIOD,
   input  logic                               clear_overflow,
   output logic                               overflow,
   output logic [15:0]                        drop_count,
   output logic [$clog2(FIFO_DEPTH):0]        fifo_level
);

   localparam int unsigned ADDR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned PTR_W  = ADDR_W + 1;
   localparam int unsigned LVL_W  = ADDR_W + 1;

   localparam logic [LC_ADDR_WIDTH:0] ADDR_LO = (LC_ADDR_WIDTH+1)'(LC_BASE_ADDRESS);
   localparam logic [LC_ADDR_WIDTH:0] ADDR_HI = (LC_ADDR_WIDTH+1)'(LC_BASE_ADDRESS + NUM_CHANNELS);

   typedef struct packed {
      logic [2:0]                 user;
      logic [CHAN_WIDTH-1:0]      dest;
      logic [AXIS_DATA_WIDTH-1:0] data;
   } entry_t;

   // Strobe synchroniser and rising-edge detector; reset to 1 so a held strobe never fires
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   strobe_prev_q;
   logic                   strobe_pulse_c;

   always_ff @(posedge m_axis_aclk) begin
      if (m_axis_areset) begin
         sync_q        <= '1;
         strobe_prev_q <= 1'b1;
      end else begin
         sync_q        <= {sync_q[SYNC_STAGES-2:0], DIOD[0]};
         strobe_prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign strobe_pulse_c = sync_q[SYNC_STAGES-1] & ~strobe_prev_q;

   // Address decode and entry formation, sampled straight from the pins
   logic [LC_DATA_WIDTH-1:0]   lc_data_c;
   logic [LC_ADDR_WIDTH-1:0]   chan_full_c;
   logic [AXIS_DATA_WIDTH-1:0] conv_data_c;
   logic                       in_range_c;
   logic                       capture_c;
   entry_t                     push_entry_c;

   assign lc_data_c   = {DIOA, DIOB};
   assign chan_full_c = DIOC - LC_ADDR_WIDTH'(LC_BASE_ADDRESS);
   assign in_range_c  = ({1'b0, DIOC} >= ADDR_LO) && ({1'b0, DIOC} < ADDR_HI);
   assign capture_c   = strobe_pulse_c & ~DIOD[1] & in_range_c;

   if (AXIS_DATA_WIDTH == LC_DATA_WIDTH) begin : g_pass
      assign conv_data_c = lc_data_c;
   end else if (AXIS_DATA_WIDTH < LC_DATA_WIDTH) begin : g_trunc
      assign conv_data_c = lc_data_c[AXIS_DATA_WIDTH-1:0];
   end else if (SIGN_EXTEND != 0) begin : g_sext
      assign conv_data_c = {{(AXIS_DATA_WIDTH-LC_DATA_WIDTH){lc_data_c[LC_DATA_WIDTH-1]}}, lc_data_c};
   end else begin : g_zext
      assign conv_data_c = {{(AXIS_DATA_WIDTH-LC_DATA_WIDTH){1'b0}}, lc_data_c};
   end

   assign push_entry_c.user = DIOD[4:2];
   assign push_entry_c.dest = CHAN_WIDTH'(chan_full_c);
   assign push_entry_c.data = conv_data_c;

   // Reserved pins and high channel bits carry no meaning here
   logic unused_bits_c;
   assign unused_bits_c = ^{DIOD[7:5], chan_full_c, lc_data_c};

   // FIFO control; capacity counts the output stage, so a pop frees room for a same-cycle push
   entry_t               mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q;
   logic [PTR_W-1:0]     rd_ptr_q;
   logic [LVL_W-1:0]     level_q;
   logic                 mem_empty_c;
   logic                 full_c;
   logic                 pop_c;
   logic                 push_c;
   logic                 drop_c;
   logic                 load_c;
   entry_t               rd_entry_c;

   assign mem_empty_c = (wr_ptr_q == rd_ptr_q);
   assign full_c      = (level_q == LVL_W'(FIFO_DEPTH));
   assign pop_c       = m_axis_tvalid & m_axis_tready;
   assign push_c      = capture_c & (~full_c | pop_c);
   assign drop_c      = capture_c & full_c & ~pop_c;
   assign load_c      = ~mem_empty_c & (~m_axis_tvalid | pop_c);
   assign rd_entry_c  = mem[rd_ptr_q[ADDR_W-1:0]];

   always_ff @(posedge m_axis_aclk) begin
      if (push_c) begin
         mem[wr_ptr_q[ADDR_W-1:0]] <= push_entry_c;
      end
   end

   always_ff @(posedge m_axis_aclk) begin
      if (m_axis_areset) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         level_q       <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tdest  <= '0;
         m_axis_tuser  <= '0;
      end else begin
         if (push_c) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (load_c) begin
            rd_ptr_q      <= rd_ptr_q + PTR_W'(1);
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= rd_entry_c.data;
            m_axis_tdest  <= rd_entry_c.dest;
            m_axis_tuser  <= rd_entry_c.user;
         end else if (pop_c) begin
            m_axis_tvalid <= 1'b0;
         end
         level_q <= level_q + LVL_W'(push_c) - LVL_W'(pop_c);
      end
   end

   assign fifo_level = level_q;

   // Overflow accounting; a clear in the same cycle as a drop takes precedence
   always_ff @(posedge m_axis_aclk) begin
      if (m_axis_areset) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (clear_overflow) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (drop_c) begin
         overflow <= 1'b1;
         if (drop_count != 16'hFFFF) begin
            drop_count <= drop_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_axis_labcontrol_multichannel.sv
// Scoreboard bench: stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_axis_labcontrol_multichannel;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned BASE  = 'hF0;
   localparam int unsigned NCH   = 4;

   logic        clk;
   logic        areset;
   logic        tready;
   logic        clear_ovf;
   logic [7:0]  dioa, diob, dioc, diod;

   logic [15:0] tdata;
   logic        tvalid;
   logic [3:0]  tdest;
   logic [2:0]  tuser;
   logic        ovf;
   logic [15:0] drops;
   logic [3:0]  level;

   logic [23:0] sx_tdata, zx_tdata;
   logic        sx_tvalid, zx_tvalid;
   logic [3:0]  sx_tdest, zx_tdest;
   logic [2:0]  sx_tuser, zx_tuser;
   logic        sx_ovf, zx_ovf;
   logic [15:0] sx_drops, zx_drops;
   logic [3:0]  sx_level, zx_level;

   typedef struct packed {
      logic [15:0] data;
      logic [3:0]  dest;
      logic [2:0]  user;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   checks = 0;
   int   errors = 0;
   int   model_drops = 0;

   logic rand_ready = 1'b0;
   logic tready_dir = 1'b0;
   logic tready_rnd = 1'b0;
   assign tready = rand_ready ? tready_rnd : tready_dir;

   axis_labcontrol_multichannel dut (
      .m_axis_aclk(clk), .m_axis_areset(areset),
      .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
      .m_axis_tdest(tdest), .m_axis_tuser(tuser),
      .DIOA(dioa), .DIOB(diob), .DIOC(dioc), .DIOD(diod),
      .clear_overflow(clear_ovf), .overflow(ovf), .drop_count(drops), .fifo_level(level)
   );

   axis_labcontrol_multichannel #(.AXIS_DATA_WIDTH(24), .SIGN_EXTEND(1)) dut_sx (
      .m_axis_aclk(clk), .m_axis_areset(areset),
      .m_axis_tdata(sx_tdata), .m_axis_tvalid(sx_tvalid), .m_axis_tready(tready),
      .m_axis_tdest(sx_tdest), .m_axis_tuser(sx_tuser),
      .DIOA(dioa), .DIOB(diob), .DIOC(dioc), .DIOD(diod),
      .clear_overflow(clear_ovf), .overflow(sx_ovf), .drop_count(sx_drops), .fifo_level(sx_level)
   );

   axis_labcontrol_multichannel #(.AXIS_DATA_WIDTH(24), .SIGN_EXTEND(0)) dut_zx (
      .m_axis_aclk(clk), .m_axis_areset(areset),
      .m_axis_tdata(zx_tdata), .m_axis_tvalid(zx_tvalid), .m_axis_tready(tready),
      .m_axis_tdest(zx_tdest), .m_axis_tuser(zx_tuser),
      .DIOA(dioa), .DIOB(diob), .DIOC(dioc), .DIOD(diod),
      .clear_overflow(clear_ovf), .overflow(zx_ovf), .drop_count(zx_drops), .fifo_level(zx_level)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one host cycle; the model decides acceptance from occupancy alone
   task automatic issue(input logic [7:0] addr, input logic [15:0] data,
                        input logic [2:0] sub, input logic dir, input bit pop_same);
      int ch;
      exp_t x;
      ch = int'(addr) - int'(BASE);
      if (!dir && ch >= 0 && ch < int'(NCH)) begin
         if (q.size() < int'(DEPTH) || pop_same) begin
            x.data = data;
            x.dest = 4'(ch);
            x.user = sub;
            q.push_back(x);
         end else begin
            model_drops++;
         end
      end
      dioa = data[15:8];
      diob = data[7:0];
      dioc = addr;
      diod = {3'($urandom), sub, dir, 1'b1};
      step();
      step();
      if (pop_same) tready_dir = 1'b1;
      step();
      if (pop_same) tready_dir = 1'b0;
      step();
      diod[0] = 1'b0;
      repeat (4) step();
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while (q.size() != 0 && n < budget) begin
         step();
         n++;
      end
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: %0d beats still expected, expected 0", q.size());
      end
   endtask

   // Random ready, forced high when the model queue is getting deep
   always @(posedge clk) begin
      #1;
      if (q.size() >= 5) tready_rnd = 1'b1;
      else               tready_rnd = 1'($urandom_range(0, 1));
   end

   // Monitor: compare beats against the scoreboard and check AXIS hold rules
   logic        have_stall = 1'b0;
   logic [22:0] stall_val;
   always @(negedge clk) begin
      if (!areset && tvalid && tready) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got tdata=%h tdest=%h tuser=%h, expected no beat",
                     tdata, tdest, tuser);
         end else begin
            e = q.pop_front();
            chk("beat", 64'({tdata, tdest, tuser}), 64'({e.data, e.dest, e.user}));
            chk("sx_beat", 64'({sx_tvalid, sx_tdata}), 64'({1'b1, {8{e.data[15]}}, e.data}));
            chk("zx_beat", 64'({zx_tvalid, zx_tdata}), 64'({1'b1, 8'h00, e.data}));
         end
      end
      if (areset) begin
         have_stall = 1'b0;
      end else begin
         if (have_stall)
            chk("hold", 64'({tvalid, tdata, tdest, tuser}), 64'({1'b1, stall_val}));
         have_stall = tvalid && !tready;
         stall_val  = {tdata, tdest, tuser};
      end
   end

   initial begin
      areset = 1'b1;
      clear_ovf = 1'b0;
      dioa = '0; diob = '0; dioc = '0; diod = '0;
      repeat (3) step();
      @(negedge clk);
      chk("rst_tvalid", 64'(tvalid), 0);
      chk("rst_tdata", 64'({tdata, tdest, tuser}), 0);
      chk("rst_ovf", 64'(ovf), 0);
      chk("rst_drops", 64'(drops), 0);
      chk("rst_level", 64'(level), 0);
      step();
      areset = 1'b0;
      step();

      // Single write with exact latency
      tready_dir = 1'b1;
      fork
         issue(8'hF2, 16'h8001, 3'd5, 1'b0, 1'b0);
         begin
            for (int i = 0; i < 3; i++) begin
               @(posedge clk);
               @(negedge clk);
               chk("lat_idle", 64'(tvalid), 0);
            end
            @(posedge clk);
            @(negedge clk);
            chk("lat_valid", 64'({tvalid, tdata, tdest, tuser}), 64'({1'b1, 16'h8001, 4'd2, 3'd5}));
         end
      join
      @(negedge clk);
      chk("single_level", 64'(level), 0);
      chk("single_drained", 64'(q.size()), 0);
      step();

      // Filtering: below range, above range, host read
      issue(8'hEF, 16'h1234, 3'd1, 1'b0, 1'b0);
      issue(8'hF4, 16'h5678, 3'd2, 1'b0, 1'b0);
      issue(8'hF0, 16'h9ABC, 3'd3, 1'b1, 1'b0);
      @(negedge clk);
      chk("filt_drops", 64'(drops), 0);
      chk("filt_level", 64'({tvalid, level}), 0);
      step();

      // Backpressure until overflow
      tready_dir = 1'b0;
      for (int i = 0; i < 10; i++)
         issue(8'(BASE + (i % 4)), 16'($urandom), 3'($urandom), 1'b0, 1'b0);
      @(negedge clk);
      chk("ovf_level", 64'(level), 8);
      chk("ovf_flag", 64'(ovf), 1);
      chk("ovf_drops", 64'(drops), 64'(model_drops));
      chk("ovf_drops_abs", 64'(drops), 2);
      step();

      // Capture coinciding with a pop while full
      issue(8'hF1, 16'($urandom), 3'($urandom), 1'b0, 1'b1);
      @(negedge clk);
      chk("fullpop_level", 64'(level), 8);
      chk("fullpop_drops", 64'({ovf, drops}), 64'({1'b1, 16'(model_drops)}));
      step();
      clear_ovf = 1'b1;
      step();
      clear_ovf = 1'b0;
      model_drops = 0;
      @(negedge clk);
      chk("clear", 64'({ovf, drops}), 0);
      step();
      tready_dir = 1'b1;
      wait_drain(60);
      step();
      @(negedge clk);
      chk("drain_level", 64'({tvalid, level}), 0);
      step();

      // Strobe held high across reset release
      areset = 1'b1;
      dioc = 8'hF1;
      diod = 8'b000_010_0_1;
      repeat (3) step();
      areset = 1'b0;
      repeat (10) step();
      diod[0] = 1'b0;
      repeat (4) step();
      @(negedge clk);
      chk("held_strobe", 64'({tvalid, level}), 0);
      step();

      // Reset with queued words
      tready_dir = 1'b0;
      for (int i = 0; i < 3; i++)
         issue(8'(BASE + i), 16'($urandom), 3'($urandom), 1'b0, 1'b0);
      @(negedge clk);
      chk("queued_level", 64'(level), 3);
      step();
      areset = 1'b1;
      q.delete();
      model_drops = 0;
      @(posedge clk);
      @(negedge clk);
      chk("rst_mid_tvalid", 64'(tvalid), 0);
      chk("rst_mid_level", 64'({level, tdata}), 0);
      step();
      areset = 1'b0;
      tready_dir = 1'b1;
      repeat (12) step();
      @(negedge clk);
      chk("no_stale", 64'({tvalid, level}), 0);
      step();

      // Randomised traffic with random backpressure
      rand_ready = 1'b1;
      for (int i = 0; i < 40; i++)
         issue(8'($urandom_range(8'hEC, 8'hF7)), 16'($urandom), 3'($urandom),
               1'($urandom_range(0, 3) == 0), 1'b0);
      rand_ready = 1'b0;
      tready_dir = 1'b1;
      wait_drain(100);
      step();
      @(negedge clk);
      chk("rand_drops", 64'({ovf, drops}), 64'({model_drops != 0, 16'(model_drops)}));
      chk("rand_level", 64'(level), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/axis_labcontrol_multichannel.md
# axis_labcontrol_multichannel

Multi-channel LabControl-bus receiver. Decodes host write strobes addressed to a contiguous block of NUM_CHANNELS addresses starting at LC_BASE_ADDRESS. Buffers each captured word with its channel index and sub-bus tag in an internal FIFO, and emits the words on a single AXI4-Stream master with TDEST/TUSER. It sits between the external DIO connector pins and the downstream AXIS fabric. Over its single-address predecessor it adds address-range decode, buffering, overflow accounting and a glitch-free reset.

## Interface
- AXIS_DATA_WIDTH, 16: width of m_axis_tdata.
- LC_DATA_WIDTH, 16: LabControl data width; fixed by the pin map {DIOA, DIOB}.
- LC_ADDR_WIDTH, 8: LabControl address width; fixed by the pin map, address = DIOC.
- LC_BASE_ADDRESS, 'hF0: address of channel 0.
- NUM_CHANNELS, 4: channels decoded, 1..16. Requires LC_BASE_ADDRESS+NUM_CHANNELS ≤ 256.
- CHAN_WIDTH, 4: width of m_axis_tdest.
- FIFO_DEPTH, 8: buffer entries; power of two, 2..256.
- SIGN_EXTEND, 1: 1 = sign-extend, 0 = zero-extend when AXIS_DATA_WIDTH > LC_DATA_WIDTH.
- SYNC_STAGES, 2: strobe synchroniser depth, ≥2.
- m_axis_aclk  in  1  single clock for all logic.
- m_axis_areset  in  1  synchronous, active-high reset.
- m_axis_tdata  out  AXIS_DATA_WIDTH  captured data word.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tdest  out  CHAN_WIDTH  channel index = address − LC_BASE_ADDRESS.
- m_axis_tuser  out  3  sub-bus field DIOD[4:2] at capture time.
- DIOA, DIOB, DIOC, DIOD  in  8 each  LabControl pins: DIOA = data[15:8], DIOB = data[7:0], DIOC = address, DIOD[7:5] = reserved (ignored), DIOD[4:2] = sub-bus, DIOD[1] = direction, DIOD[0] = strobe.
- clear_overflow  in  1  single-cycle pulse; clears overflow and drop_count.
- overflow  out  1  sticky; set when any word is dropped.
- drop_count  out  16  number of dropped words; saturates at 16'hFFFF.
- fifo_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Strobe path: DIOD[0] passes through a SYNC_STAGES-flop synchroniser, then a rising-edge detector (previous-value flop). The result is strobe_pulse, one cycle wide.
- Reset value of the synchroniser flops and the edge flop is 1. A strobe held high across reset release therefore produces no pulse.
- Capture condition: strobe_pulse & (DIOD[1] == 0) & (LC_BASE_ADDRESS ≤ DIOC < LC_BASE_ADDRESS+NUM_CHANNELS).
- Direction 1 (host read) and out-of-range addresses are ignored silently and are not counted as drops.
- On capture, DIOA/DIOB/DIOC/DIOD are sampled directly from the pins in the pulse cycle. The host keeps them stable for ≥ SYNC_STAGES+2 clocks after the strobe rises.
- Pushed entry = {DIOD[4:2], DIOC − LC_BASE_ADDRESS, {DIOA, DIOB}}.
- FIFO: circular buffer with read/write pointers one bit wider than the address, and a registered output stage (first-word-fall-through behaviour).
- Push when full:
  - Without a pop in the same cycle: the word is dropped, overflow is set to 1, and drop_count increments (saturating).
  - With a pop in the same cycle: the push is accepted and nothing is dropped.
- Pop occurs when m_axis_tvalid & m_axis_tready.
- clear_overflow in the same cycle as a drop: the clear wins for that cycle; overflow = 0, drop_count = 0, and the drop is not recorded.
- Width conversion of tdata:
  - Equal widths: pass through.
  - AXIS_DATA_WIDTH < LC_DATA_WIDTH: keep the LSBs.
  - AXIS_DATA_WIDTH > LC_DATA_WIDTH: replicate bit 15 if SIGN_EXTEND, else pad with zeros.
- AXIS rules:
  - tdata/tdest/tuser are stable while tvalid=1 and tready=0.
  - tvalid never drops without a handshake.
  - Entries are delivered in capture order.
- Reset (any time, including mid-stream or mid-strobe): FIFO flushed, tvalid=0, tdata=0, tdest=0, tuser=0, overflow=0, drop_count=0, fifo_level=0. Words in flight are lost and not counted.

## Timing
- Edge 0 = first clock edge sampling DIOD[0]=1.
- strobe_pulse is high during the cycle after edge SYNC_STAGES−1.
- FIFO write occurs at edge SYNC_STAGES.
- tvalid rises after edge SYNC_STAGES+1 when the FIFO was empty and the output stage idle. Total latency is SYNC_STAGES+2 edges, i.e. 4 with defaults.
- fifo_level updates one cycle after a push or pop, and counts the entry held in the output stage.
- Throughput: one word per clock on the output when tready is held high. Capture rate is limited by the strobe to one per ≥ 2×(SYNC_STAGES+1) clocks.
- overflow and drop_count update at the edge of the dropped push.

## Test plan
- Single write: addr 0xF2, data 0x8001, subbus 5, tready=1, defaults → exactly one beat 4 edges after strobe; tdata 0x8001, tdest 2, tuser 5.
- Sign extension: AXIS_DATA_WIDTH=24, data 0x8001 → tdata 0xFF8001. With SIGN_EXTEND=0 → tdata 0x008001.
- Filtering: addr 0xEF, addr 0xF4, and addr 0xF0 with DIOD[1]=1 → no beats, drop_count stays 0.
- Backpressure/overflow: tready=0, 10 writes to 0xF0..0xF3 with FIFO_DEPTH=8 → fifo_level 8, overflow=1, drop_count=2. Then tready=1 → exactly the first 8 words, in order.
- Full plus pop: FIFO full, capture in the same cycle as a handshake → no drop, level stays 8. clear_overflow → overflow=0, drop_count=0.
- Reset: DIOD[0] held high through reset release → no beat. Reset asserted with 3 words queued → tvalid=0 next cycle, fifo_level=0, and no stale word appears afterwards.
